// File: rtl/tile_scheduler_pkg.sv
// Shared raster types and constants for the tile scheduling path.
// Fixed point is 12.4; tiles are 2**TILE_SHIFT_PX pixels on a side.
package tile_scheduler_pkg;

    localparam int FX_TOTAL_BITS     = 16;
    localparam int FX_FRAC_BITS      = 4;
    localparam int FX_INT_BITS       = FX_TOTAL_BITS - FX_FRAC_BITS;
    localparam int TILE_COLUMNS_BITS = 5;
    localparam int TILE_ROWS_BITS    = 4;
    localparam int TILE_SHIFT_PX     = 5;

    typedef struct packed {
        logic [FX_TOTAL_BITS-1:0] x;
        logic [FX_TOTAL_BITS-1:0] y;
        logic [FX_TOTAL_BITS-1:0] z;
    } coord_3d_t;

    typedef struct packed {
        logic [11:0]                  tri_id;
        logic [7:0]                   flags;
        logic [TILE_COLUMNS_BITS-1:0] tile_x;
        logic [TILE_ROWS_BITS-1:0]    tile_y;
    } metadata_t;

    typedef enum logic [1:0] {S_IDLE, S_BBOX, S_ISSUE} sched_state_t;

    typedef logic signed [FX_INT_BITS-1:0] fx_int_t;

    function automatic fx_int_t smin(input fx_int_t a, input fx_int_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic fx_int_t smax(input fx_int_t a, input fx_int_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic fx_int_t clamp_tile(input fx_int_t v, input fx_int_t hi);
        if (v < fx_int_t'(0)) return fx_int_t'(0);
        if (v > hi)           return hi;
        return v;
    endfunction

endpackage

// File: rtl/tile_bbox.sv
// Combinational bounding box of a triangle in tile units, clamped to the screen.
// Emptiness is judged on the unclamped extents, before any clamping hides it.
module tile_bbox
    import tile_scheduler_pkg::*;
#(
    parameter int TILE_COLS  = 20,
    parameter int TILE_ROWS  = 15,
    parameter int TILE_SHIFT = TILE_SHIFT_PX
) (
    input  logic signed [FX_INT_BITS-1:0] px [3],
    input  logic signed [FX_INT_BITS-1:0] py [3],
    output logic [TILE_COLUMNS_BITS-1:0]  min_x,
    output logic [TILE_COLUMNS_BITS-1:0]  max_x,
    output logic [TILE_ROWS_BITS-1:0]     min_y,
    output logic [TILE_ROWS_BITS-1:0]     max_y,
    output logic                          empty
);

    localparam fx_int_t COL_LIM = fx_int_t'(TILE_COLS - 1);
    localparam fx_int_t ROW_LIM = fx_int_t'(TILE_ROWS - 1);
    localparam fx_int_t ZERO    = fx_int_t'(0);

    fx_int_t tx [3];
    fx_int_t ty [3];
    fx_int_t tmin_x, tmax_x, tmin_y, tmax_y;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_tile_idx
            assign tx[gi] = px[gi] >>> TILE_SHIFT;
            assign ty[gi] = py[gi] >>> TILE_SHIFT;
        end
    endgenerate

    assign tmin_x = smin(smin(tx[0], tx[1]), tx[2]);
    assign tmax_x = smax(smax(tx[0], tx[1]), tx[2]);
    assign tmin_y = smin(smin(ty[0], ty[1]), ty[2]);
    assign tmax_y = smax(smax(ty[0], ty[1]), ty[2]);

    assign empty = (tmax_x < ZERO) || (tmax_y < ZERO) ||
                   (tmin_x > COL_LIM) || (tmin_y > ROW_LIM);

    assign min_x = TILE_COLUMNS_BITS'(clamp_tile(tmin_x, COL_LIM));
    assign max_x = TILE_COLUMNS_BITS'(clamp_tile(tmax_x, COL_LIM));
    assign min_y = TILE_ROWS_BITS'(clamp_tile(tmin_y, ROW_LIM));
    assign max_y = TILE_ROWS_BITS'(clamp_tile(tmax_y, ROW_LIM));

endmodule

// File: rtl/tile_scheduler.sv
// Walks the clamped tile bounding box of one triangle in row-major order,
// issuing one vertex/metadata transaction per tile over valid/ready.
module tile_scheduler
    import tile_scheduler_pkg::*;
#(
    parameter int TILE_COLS  = 20,
    parameter int TILE_ROWS  = 15,
    parameter int TILE_SHIFT = TILE_SHIFT_PX
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      vld_in,
    output logic      rdy_in,
    input  coord_3d_t v0,
    input  coord_3d_t v1,
    input  coord_3d_t v2,
    input  metadata_t in_metadata,
    output logic      vld_out,
    input  logic      rdy_out,
    output coord_3d_t out_v0,
    output coord_3d_t out_v1,
    output coord_3d_t out_v2,
    output metadata_t out_metadata,
    output logic      out_last,
    output logic      tri_done,
    output logic      busy
);

    sched_state_t                 state_reg, state_next;
    coord_3d_t                    v_reg [3];
    metadata_t                    meta_reg;
    logic [TILE_COLUMNS_BITS-1:0] min_x_reg, max_x_reg;
    logic [TILE_ROWS_BITS-1:0]    max_y_reg;
    logic                         done_reg;

    logic signed [FX_INT_BITS-1:0] px [3];
    logic signed [FX_INT_BITS-1:0] py [3];
    logic [TILE_COLUMNS_BITS-1:0]  bb_min_x, bb_max_x;
    logic [TILE_ROWS_BITS-1:0]     bb_min_y, bb_max_y;
    logic                          bb_empty;
    logic                          is_last;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pixel
            assign px[gi] = v_reg[gi].x[FX_TOTAL_BITS-1:FX_FRAC_BITS];
            assign py[gi] = v_reg[gi].y[FX_TOTAL_BITS-1:FX_FRAC_BITS];
        end
    endgenerate

    tile_bbox #(
        .TILE_COLS  (TILE_COLS),
        .TILE_ROWS  (TILE_ROWS),
        .TILE_SHIFT (TILE_SHIFT)
    ) u_bbox (
        .px    (px),
        .py    (py),
        .min_x (bb_min_x),
        .max_x (bb_max_x),
        .min_y (bb_min_y),
        .max_y (bb_max_y),
        .empty (bb_empty)
    );

    // The tile_x/tile_y fields of meta_reg double as the current-tile counters.
    assign is_last = (meta_reg.tile_x == max_x_reg) && (meta_reg.tile_y == max_y_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        rdy_in     = 1'b0;
        vld_out    = 1'b0;
        out_last   = 1'b0;
        busy       = 1'b1;
        unique case (state_reg)
            S_IDLE: begin
                rdy_in = 1'b1;
                busy   = 1'b0;
                if (vld_in) state_next = S_BBOX;
            end
            S_BBOX:  state_next = bb_empty ? S_IDLE : S_ISSUE;
            S_ISSUE: begin
                vld_out  = 1'b1;
                out_last = is_last;
                if (rdy_out && is_last) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) v_reg[i] <= '0;
            meta_reg  <= '0;
            min_x_reg <= '0;
            max_x_reg <= '0;
            max_y_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: if (vld_in) begin
                    v_reg[0] <= v0;
                    v_reg[1] <= v1;
                    v_reg[2] <= v2;
                    meta_reg <= in_metadata;
                end
                S_BBOX: if (bb_empty) begin
                    done_reg <= 1'b1;
                end else begin
                    min_x_reg       <= bb_min_x;
                    max_x_reg       <= bb_max_x;
                    max_y_reg       <= bb_max_y;
                    meta_reg.tile_x <= bb_min_x;
                    meta_reg.tile_y <= bb_min_y;
                end
                S_ISSUE: if (rdy_out) begin
                    if (is_last) begin
                        done_reg <= 1'b1;
                    end else if (meta_reg.tile_x == max_x_reg) begin
                        meta_reg.tile_x <= min_x_reg;
                        meta_reg.tile_y <= meta_reg.tile_y + 1'b1;
                    end else begin
                        meta_reg.tile_x <= meta_reg.tile_x + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_v0       = v_reg[0];
    assign out_v1       = v_reg[1];
    assign out_v2       = v_reg[2];
    assign out_metadata = meta_reg;
    assign tri_done     = done_reg;

endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler: directed table, reset abort and random triangles
// compared against a floor-division bounding-box model.
module tb_tile_scheduler;
    import tile_scheduler_pkg::*;

    localparam int COLS = 20;
    localparam int ROWS = 15;

    logic      clk = 1'b0;
    logic      rst_n, vld_in, rdy_in, vld_out, rdy_out, out_last, tri_done, busy;
    coord_3d_t v0, v1, v2, out_v0, out_v1, out_v2;
    metadata_t in_metadata, out_metadata;

    int n_vec = 0;
    int n_bad = 0;
    int n_tri = 0;

    tile_scheduler #(.TILE_COLS(COLS), .TILE_ROWS(ROWS), .TILE_SHIFT(TILE_SHIFT_PX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vld_in       (vld_in),
        .rdy_in       (rdy_in),
        .v0           (v0),
        .v1           (v1),
        .v2           (v2),
        .in_metadata  (in_metadata),
        .vld_out      (vld_out),
        .rdy_out      (rdy_out),
        .out_v0       (out_v0),
        .out_v1       (out_v1),
        .out_v2       (out_v2),
        .out_metadata (out_metadata),
        .out_last     (out_last),
        .tri_done     (tri_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x0, y0, x1, y1, x2, y2;
        int ex0, ex1, ey0, ey1;
        bit empty;
        int stall_at, stall_len;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int floor_tile(input int p);
        int t;
        t = 1 << TILE_SHIFT_PX;
        return (p >= 0) ? p / t : -((t - 1 - p) / t);
    endfunction

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic coord_3d_t mk(input int px, input int py);
        coord_3d_t c;
        c.x = 16'(px * 16 + int'($urandom_range(0, 15)));
        c.y = 16'(py * 16 + int'($urandom_range(0, 15)));
        c.z = 16'($urandom);
        return c;
    endfunction

    task automatic run_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2,
                           input int ex0, input int ex1, input int ey0, input int ey1,
                           input bit empty, input int stall_at, input int stall_len,
                           input bit rnd_rdy, input int abort_at);
        coord_3d_t a, b, c;
        metadata_t m, em;
        int qx[$], qy[$];
        int idx, n, stalls, lim;
        bit done;
        a = mk(x0, y0);
        b = mk(x1, y1);
        c = mk(x2, y2);
        m.tri_id = 12'($urandom);
        m.flags  = 8'($urandom);
        m.tile_x = TILE_COLUMNS_BITS'($urandom);
        m.tile_y = TILE_ROWS_BITS'($urandom);
        if (!empty)
            for (int y = ey0; y <= ey1; y++)
                for (int x = ex0; x <= ex1; x++) begin
                    qx.push_back(x);
                    qy.push_back(y);
                end
        n = qx.size();
        n_tri++;

        @(negedge clk);
        chk("idle_rdy_in", 64'(rdy_in), 64'(1));
        chk("idle_tri_done", 64'(tri_done), 64'(0));
        v0 = a; v1 = b; v2 = c; in_metadata = m;
        vld_in  = 1'b1;
        rdy_out = 1'b0;
        @(negedge clk);
        vld_in = 1'b0;
        chk("bbox_rdy_in", 64'(rdy_in), 64'(0));
        chk("bbox_vld_out", 64'(vld_out), 64'(0));
        chk("bbox_busy", 64'(busy), 64'(1));
        chk("bbox_tri_done", 64'(tri_done), 64'(0));

        idx = 0;
        stalls = stall_len;
        done = 1'b0;
        lim = 4 * n + stall_len + 20;
        for (int k = 2; k < lim; k++) begin
            @(negedge clk);
            if (abort_at >= 0 && idx == abort_at) begin
                rdy_out = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("abort_vld_out", 64'(vld_out), 64'(0));
                chk("abort_rdy_in", 64'(rdy_in), 64'(1));
                chk("abort_busy", 64'(busy), 64'(0));
                chk("abort_out_last", 64'(out_last), 64'(0));
                chk("abort_out_v0", 64'(out_v0), 64'(0));
                chk("abort_meta", 64'(out_metadata), 64'(0));
                repeat (2) begin
                    @(negedge clk);
                    chk("abort_tri_done", 64'(tri_done), 64'(0));
                end
                rst_n = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    chk("post_abort_tri_done", 64'(tri_done), 64'(0));
                    chk("post_abort_rdy_in", 64'(rdy_in), 64'(1));
                end
                $display("tri %0d: aborted by reset at tile %0d of %0d", n_tri, idx, n);
                return;
            end
            if (idx < n) begin
                em = m;
                em.tile_x = TILE_COLUMNS_BITS'(qx[idx]);
                em.tile_y = TILE_ROWS_BITS'(qy[idx]);
                chk("issue_vld_out", 64'(vld_out), 64'(1));
                chk("issue_meta", 64'(out_metadata), 64'(em));
                chk("issue_last", 64'(out_last), 64'(idx == n - 1));
                chk("issue_tri_done", 64'(tri_done), 64'(0));
                chk("issue_rdy_in", 64'(rdy_in), 64'(0));
                chk("issue_v0", 64'(out_v0), 64'(a));
                chk("issue_v1", 64'(out_v1), 64'(b));
                chk("issue_v2", 64'(out_v2), 64'(c));
                if (idx == stall_at && stalls > 0) begin
                    rdy_out = 1'b0;
                    stalls--;
                end else if (rnd_rdy) begin
                    rdy_out = ($urandom_range(0, 3) != 0);
                end else begin
                    rdy_out = 1'b1;
                end
                if (rdy_out) idx++;
            end else begin
                chk("end_vld_out", 64'(vld_out), 64'(0));
                chk("end_tri_done", 64'(tri_done), 64'(1));
                chk("end_rdy_in", 64'(rdy_in), 64'(1));
                chk("end_busy", 64'(busy), 64'(0));
                rdy_out = 1'b0;
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: tri %0d issued %0d of %0d tiles without finishing", n_tri, idx, n);
        end
        $display("tri %0d: %0d tiles, bbox x %0d..%0d y %0d..%0d%s", n_tri, n, ex0, ex1, ey0, ey1,
                 empty ? " (empty)" : "");
    endtask

    initial begin
        rst_n = 1'b0; vld_in = 1'b0; rdy_out = 1'b0;
        v0 = '0; v1 = '0; v2 = '0; in_metadata = '0;
        #1;
        chk("rst_rdy_in", 64'(rdy_in), 64'(1));
        chk("rst_vld_out", 64'(vld_out), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_tri_done", 64'(tri_done), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_meta", 64'(out_metadata), 64'(0));
        chk("rst_v0", 64'(out_v0), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //           x0   y0   x1   y1   x2   y2   ex0 ex1 ey0 ey1 empty stall_at len
        tbl[0]  = '{ 10,  10,  40,  10,  10,  40,  0,  1,  0,  1, 1'b0, -1, 0};
        tbl[1]  = '{-50, -20,  20,  -5,   5,  30,  0,  0,  0,  0, 1'b0, -1, 0};
        tbl[2]  = '{700,  10, 720,  10, 700,  40,  0,  0,  0,  0, 1'b1, -1, 0};
        tbl[3]  = '{ 10,  10,  40,  10,  10,  40,  0,  1,  0,  1, 1'b0,  1, 5};
        tbl[4]  = '{600, 440, 700, 470, 620, 520, 18, 19, 13, 14, 1'b0, -1, 0};
        tbl[5]  = '{100, 100, 100, 100, 100, 100,  3,  3,  3,  3, 1'b0, -1, 0};
        tbl[6]  = '{639, 479, 639, 479, 639, 479, 19, 19, 14, 14, 1'b0, -1, 0};
        tbl[7]  = '{640, 100, 650, 200, 700, 300,  0,  0,  0,  0, 1'b1, -1, 0};
        tbl[8]  = '{ 10,  -1,  20, -40,  30, -33,  0,  0,  0,  0, 1'b1, -1, 0};
        tbl[9]  = '{-300, 100, 900, 110,  0, 120,  0, 19,  3,  3, 1'b0,  7, 2};
        tbl[10] = '{ 33,   5,  33, 100,  33, 200,  1,  1,  0,  6, 1'b0, -1, 0};

        for (int i = 0; i < 11; i++)
            run_tri(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2,
                    tbl[i].ex0, tbl[i].ex1, tbl[i].ey0, tbl[i].ey1, tbl[i].empty,
                    tbl[i].stall_at, tbl[i].stall_len, 1'b0, -1);

        // Reset during the third tile of the 2x2 case, then the same triangle from scratch.
        run_tri(10, 10, 40, 10, 10, 40, 0, 1, 0, 1, 1'b0, -1, 0, 1'b0, 2);
        run_tri(10, 10, 40, 10, 10, 40, 0, 1, 0, 1, 1'b0, -1, 0, 1'b0, -1);

        for (int t = 0; t < 40; t++) begin
            int xs0, ys0, xs1, ys1, xs2, ys2, mnx, mxx, mny, mxy;
            bit emp;
            xs0 = int'($urandom_range(0, 1000)) - 200;
            ys0 = int'($urandom_range(0, 800)) - 150;
            xs1 = xs0 + int'($urandom_range(0, 200)) - 100;
            ys1 = ys0 + int'($urandom_range(0, 200)) - 100;
            xs2 = xs0 + int'($urandom_range(0, 200)) - 100;
            ys2 = ys0 + int'($urandom_range(0, 200)) - 100;
            mnx = min3(floor_tile(xs0), floor_tile(xs1), floor_tile(xs2));
            mxx = max3(floor_tile(xs0), floor_tile(xs1), floor_tile(xs2));
            mny = min3(floor_tile(ys0), floor_tile(ys1), floor_tile(ys2));
            mxy = max3(floor_tile(ys0), floor_tile(ys1), floor_tile(ys2));
            emp = (mxx < 0) || (mxy < 0) || (mnx >= COLS) || (mny >= ROWS);
            run_tri(xs0, ys0, xs1, ys1, xs2, ys2,
                    clampi(mnx, COLS - 1), clampi(mxx, COLS - 1),
                    clampi(mny, ROWS - 1), clampi(mxy, ROWS - 1),
                    emp, -1, 0, 1'b1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
